link_pipe: RTL

Carries link-register writes (jal, jalr, bgezal, bltzal) from the decode stage through the EX, MEM and WB pipeline registers of the forwarding pipeline. It consumes the decode-stage `rf31Write` flag and the instruction PC and computes the return address (PC+8). Per stage it exposes the pending link destination and value, which the forwarding unit uses to resolve hazards on the link register. It delivers the final write request to the register-file write port in WB, and keeps a saturating count of retired link writes.

---
 rtl/link_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/link_pipe.sv
// link_pipe -- link-register write carrier for the EX/MEM/WB pipeline.
//
// Purpose:
//   Takes the decode-stage link-write flag (jal/jalr/bgezal/bltzal) and the
//   instruction PC, forms the return address (PC+8) and the destination
//   register, and moves that entry through the EX, MEM and WB registers.
//   Each stage's pending destination and value are exposed so the forwarding
//   unit can resolve hazards on the link register. WB drives the register-file
//   write port. A saturating counter tracks retired link writes.
//
// Configuration macro:
//   LINK_JALR_RD_EN -- when defined, jalr (id_jr == 2'b10) writes id_rd
//                      instead of LINK_REG; jalr with rd=0 writes nothing.
//                      When undefined, every link write targets LINK_REG.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   stall          in   ID held; bubble into EX
//   flush          in   ID killed; bubble into EX
//   id_rf31Write   in   ID instruction writes a link register
//   id_jr  [1:0]   in   jr control code (2'b10 = jalr)
//   id_rd  [4:0]   in   rd field of the ID instruction
//   id_pc  [31:0]  in   PC of the ID instruction
//   ex_link_*      out  EX pending link write (valid/addr/data)
//   mem_link_*     out  MEM pending link write (valid/addr/data)
//   wb_link_*      out  register-file write port (we/addr/data)
//   link_cnt       out  saturating count of retired link writes

module link_pipe #(
  parameter logic [4:0] LINK_REG = 5'd31,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_rf31Write,
  input  logic [1:0]       id_jr,
  input  logic [4:0]       id_rd,
  input  logic [31:0]      id_pc,
  output logic             ex_link_valid,
  output logic [4:0]       ex_link_addr,
  output logic [31:0]      ex_link_data,
  output logic             mem_link_valid,
  output logic [4:0]       mem_link_addr,
  output logic [31:0]      mem_link_data,
  output logic             wb_link_we,
  output logic [4:0]       wb_link_addr,
  output logic [31:0]      wb_link_data,
  output logic [CNT_W-1:0] link_cnt
);

  typedef struct packed {
    logic        vld;
    logic [4:0]  addr;
    logic [31:0] data;
  } link_ent_t;

  localparam link_ent_t BUBBLE = '{vld: 1'b0, addr: 5'd0, data: 32'd0};
  localparam int        STAGES = 3;   // 0 = EX, 1 = MEM, 2 = WB

  link_ent_t               stg_q [STAGES];
  link_ent_t               id_ent;
  link_ent_t               ex_d;
  logic [4:0]              id_dst;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Destination selection for the ID instruction.
`ifdef LINK_JALR_RD_EN
  assign id_dst = (id_jr == 2'b10) ? id_rd : LINK_REG;
`else
  assign id_dst = LINK_REG;
  logic unused_id;
  assign unused_id = ^{id_jr, id_rd};
`endif

  // Entry formed from the ID instruction. A zero destination never writes,
  // so it is dropped to a valid=0 entry here rather than at WB.
  always_comb begin
    id_ent      = BUBBLE;
    id_ent.addr = id_dst;
    id_ent.data = id_pc + 32'd8;   // wraps modulo 2^32
    id_ent.vld  = id_rf31Write && (id_dst != 5'd0);
  end

  // A stalled or flushed ID inserts a full bubble (addr/data cleared too,
  // so forwarding comparators never see a stale destination).
  always_comb begin
    ex_d = BUBBLE;
    if (!stall && !flush)
      ex_d = id_ent;
  end

  // Retire counter saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (stg_q[2].vld && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // EX/MEM/WB advance every cycle; stall only affects what enters EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++)
        stg_q[s] <= BUBBLE;
      cnt_q <= '0;
    end else begin
      stg_q[0] <= ex_d;
      for (int s = 1; s < STAGES; s++)
        stg_q[s] <= stg_q[s-1];
      cnt_q <= cnt_d;
    end
  end

  assign ex_link_valid  = stg_q[0].vld;
  assign ex_link_addr   = stg_q[0].addr;
  assign ex_link_data   = stg_q[0].data;
  assign mem_link_valid = stg_q[1].vld;
  assign mem_link_addr  = stg_q[1].addr;
  assign mem_link_data  = stg_q[1].data;
  assign wb_link_we     = stg_q[2].vld;
  assign wb_link_addr   = stg_q[2].addr;
  assign wb_link_data   = stg_q[2].data;
  assign link_cnt       = cnt_q;

endmodule
